// File: rtl/top3_stream_reader.sv
// ---------------------------------------------------------------------------
// top3_stream_reader
//
// Snapshot reader for the top-3 tracker. On a snapshot request in IDLE it
// captures the tracker's three result registers (largest first), pulses
// clear_req so the tracker starts a new window, and then streams the
// non-empty captured entries over a valid/ready master interface, marking
// the final beat with m_last. If every captured slot is empty, a single
// marker beat (m_data = EMPTY_VAL, m_index = 3, m_last = 1) is sent.
//
// Ports:
//   clk           clock, rising edge
//   reset         asynchronous, active-high reset
//   snap_req      snapshot request (pulse or level), accepted only when idle
//   res_0..res_2  tracker results: third-largest, second-largest, largest
//   clear_req     one-cycle pulse asking the tracker to clear its window
//   busy          high from capture until the last beat is accepted
//   m_valid       beat valid
//   m_ready       downstream accepts beat
//   m_data        captured value of the current beat
//   m_index       rank of the beat (0 = largest .. 2), 3 = empty-frame marker
//   m_last        final beat of the frame
//   dropped_snaps saturating count of snap_req cycles seen while busy
// ---------------------------------------------------------------------------
module top3_stream_reader #(
  parameter int                 DATA_W    = 32,
  parameter logic [DATA_W-1:0]  EMPTY_VAL = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              snap_req,
  input  logic [DATA_W-1:0] res_0,
  input  logic [DATA_W-1:0] res_1,
  input  logic [DATA_W-1:0] res_2,
  output logic              clear_req,
  output logic              busy,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [1:0]        m_index,
  output logic              m_last,
  output logic [7:0]        dropped_snaps
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] buf_q [3];
  logic [DATA_W-1:0] buf_d [3];
  logic [2:0]        mask_q, mask_d;
  logic              clear_q, clear_d;
  logic [7:0]        dropped_q, dropped_d;

  // Rank of the beat on offer and what would remain after it is taken.
  logic [1:0]        rank_s;
  logic [2:0]        remain_s;
  logic              handshake_s;

  // State, capture buffer, mask, clear pulse and drop counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      buf_q[0]  <= '0;
      buf_q[1]  <= '0;
      buf_q[2]  <= '0;
      mask_q    <= 3'b000;
      clear_q   <= 1'b0;
      dropped_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      buf_q[0]  <= buf_d[0];
      buf_q[1]  <= buf_d[1];
      buf_q[2]  <= buf_d[2];
      mask_q    <= mask_d;
      clear_q   <= clear_d;
      dropped_q <= dropped_d;
    end
  end

  // Lowest set mask bit is the next beat; rank 3 means the frame was empty.
  always_comb begin
    rank_s   = 2'd3;
    remain_s = 3'b000;
    if (mask_q[0]) begin
      rank_s   = 2'd0;
      remain_s = mask_q & 3'b110;
    end else if (mask_q[1]) begin
      rank_s   = 2'd1;
      remain_s = mask_q & 3'b100;
    end else if (mask_q[2]) begin
      rank_s   = 2'd2;
      remain_s = 3'b000;
    end else begin
      rank_s   = 2'd3;
      remain_s = 3'b000;
    end
  end

  // Output decode: every output is derived from registered state only.
  always_comb begin
    busy          = 1'b0;
    m_valid       = 1'b0;
    m_data        = '0;
    m_index       = 2'd0;
    m_last        = 1'b0;
    clear_req     = clear_q;
    dropped_snaps = dropped_q;
    case (state_q)
      ST_SEND: begin
        busy    = 1'b1;
        m_valid = 1'b1;
        m_index = rank_s;
        m_last  = (remain_s == 3'b000);
        case (rank_s)
          2'd0:    m_data = buf_q[0];
          2'd1:    m_data = buf_q[1];
          2'd2:    m_data = buf_q[2];
          default: m_data = EMPTY_VAL;
        endcase
      end
      default: begin
        busy    = 1'b0;
        m_valid = 1'b0;
      end
    endcase
  end

  assign handshake_s = m_valid && m_ready;

  // Next-state logic: capture on request in IDLE, retire beats in SEND.
  always_comb begin
    state_d   = state_q;
    buf_d[0]  = buf_q[0];
    buf_d[1]  = buf_q[1];
    buf_d[2]  = buf_q[2];
    mask_d    = mask_q;
    clear_d   = 1'b0;
    dropped_d = dropped_q;
    case (state_q)
      ST_IDLE: begin
        if (snap_req) begin
          buf_d[0]  = res_2;
          buf_d[1]  = res_1;
          buf_d[2]  = res_0;
          mask_d[0] = (res_2 != EMPTY_VAL);
          mask_d[1] = (res_1 != EMPTY_VAL);
          mask_d[2] = (res_0 != EMPTY_VAL);
          clear_d   = 1'b1;
          state_d   = ST_SEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (handshake_s) begin
          mask_d = remain_s;
          if (remain_s == 3'b000) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_SEND;
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Requests are dropped on every busy cycle, including the final beat.
    if (snap_req && busy && (dropped_q != 8'hFF)) begin
      dropped_d = dropped_q + 8'd1;
    end else begin
      dropped_d = dropped_q;
    end
  end

endmodule

// File: tb/tb_top3_stream_reader.sv
module tb_top3_stream_reader;

  localparam logic [31:0] E = 32'h8000_0000;

  logic        clk;
  logic        reset;
  logic        snap_req;
  logic [31:0] res_0, res_1, res_2;
  logic        clear_req, busy, m_valid, m_ready, m_last;
  logic [31:0] m_data;
  logic [1:0]  m_index;
  logic [7:0]  dropped_snaps;

  int checks   = 0;
  int failures = 0;

  top3_stream_reader #(.DATA_W(32), .EMPTY_VAL(E)) dut (
    .clk(clk), .reset(reset), .snap_req(snap_req),
    .res_0(res_0), .res_1(res_1), .res_2(res_2),
    .clear_req(clear_req), .busy(busy), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_index(m_index),
    .m_last(m_last), .dropped_snaps(dropped_snaps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue of pending beats plus a drop counter.
  typedef struct {
    logic [31:0] d;
    logic [1:0]  ix;
  } beat_t;
  beat_t q[$];
  int    mdl_drop;
  logic  mdl_clr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_capture(input logic [31:0] r2, input logic [31:0] r1, input logic [31:0] r0);
    logic [31:0] v [3];
    v[0] = r2; v[1] = r1; v[2] = r0;
    q.delete();
    for (int i = 0; i < 3; i++)
      if (v[i] != E) q.push_back('{d: v[i], ix: 2'(i)});
    if (q.size() == 0) q.push_back('{d: E, ix: 2'd3});
  endtask

  task automatic model_reset();
    q.delete();
    mdl_drop = 0;
    mdl_clr  = 1'b0;
  endtask

  // Compare every DUT output against the model's view of the current cycle.
  task automatic check_outputs();
    chk("busy", 32'(busy), 32'(q.size() > 0));
    chk("m_valid", 32'(m_valid), 32'(q.size() > 0));
    chk("clear_req", 32'(clear_req), 32'(mdl_clr));
    chk("dropped", 32'(dropped_snaps), 32'(mdl_drop));
    if (q.size() > 0) begin
      chk("m_data", m_data, q[0].d);
      chk("m_index", 32'(m_index), 32'(q[0].ix));
      chk("m_last", 32'(m_last), 32'(q.size() == 1));
    end else begin
      chk("idle_data", m_data, 32'd0);
      chk("idle_index", 32'(m_index), 32'd0);
      chk("idle_last", 32'(m_last), 32'd0);
    end
  endtask

  // One clock: apply inputs just after a negedge, advance model, check at next negedge.
  task automatic cycle(input logic snap, input logic rdy);
    snap_req = snap;
    m_ready  = rdy;
    if (q.size() > 0) begin
      if (snap && mdl_drop < 255) mdl_drop++;
      if (rdy) void'(q.pop_front());
      mdl_clr = 1'b0;
    end else if (snap) begin
      model_capture(res_2, res_1, res_0);
      mdl_clr = 1'b1;
    end else begin
      mdl_clr = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic set_res(input logic [31:0] r2, input logic [31:0] r1, input logic [31:0] r0);
    res_2 = r2; res_1 = r1; res_0 = r0;
  endtask

  function automatic logic [31:0] rnd_val();
    if ($urandom_range(0, 3) == 0) return E;
    return 32'($urandom_range(0, 20));
  endfunction

  typedef struct {
    logic [31:0] r2, r1, r0;
    int          n;
    logic [31:0] d  [3];
    logic [1:0]  ix [3];
  } vec_t;
  vec_t vt [6];

  int guard;

  initial begin
    vt[0] = '{r2: 32'd50, r1: 32'd30, r0: 32'd10, n: 3, d: '{32'd50, 32'd30, 32'd10}, ix: '{2'd0, 2'd1, 2'd2}};
    vt[1] = '{r2: 32'd7,  r1: E,      r0: E,      n: 1, d: '{32'd7, 32'd0, 32'd0},    ix: '{2'd0, 2'd0, 2'd0}};
    vt[2] = '{r2: E,      r1: E,      r0: E,      n: 1, d: '{E, 32'd0, 32'd0},        ix: '{2'd3, 2'd0, 2'd0}};
    vt[3] = '{r2: 32'd9,  r1: E,      r0: 32'd4,  n: 2, d: '{32'd9, 32'd4, 32'd0},    ix: '{2'd0, 2'd2, 2'd0}};
    vt[4] = '{r2: E,      r1: 32'd5,  r0: E,      n: 1, d: '{32'd5, 32'd0, 32'd0},    ix: '{2'd1, 2'd0, 2'd0}};
    vt[5] = '{r2: 32'd3,  r1: 32'd3,  r0: 32'd3,  n: 3, d: '{32'd3, 32'd3, 32'd3},    ix: '{2'd0, 2'd1, 2'd2}};

    reset = 1'b1; snap_req = 1'b0; m_ready = 1'b0;
    set_res(E, E, E);
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    reset = 1'b0;
    cycle(1'b0, 1'b0);

    // Table-driven frames with m_ready held high.
    for (int t = 0; t < 6; t++) begin
      set_res(vt[t].r2, vt[t].r1, vt[t].r0);
      cycle(1'b1, 1'b1);
      chk("tbl_clear_first", 32'(clear_req), 32'd1);
      for (int k = 0; k < vt[t].n; k++) begin
        chk("tbl_data", m_data, vt[t].d[k]);
        chk("tbl_index", 32'(m_index), 32'(vt[t].ix[k]));
        chk("tbl_last", 32'(m_last), 32'(k == vt[t].n - 1));
        chk("tbl_busy", 32'(busy), 32'd1);
        cycle(1'b0, 1'b1);
        chk("tbl_clear_after", 32'(clear_req), 32'd0);
      end
      chk("tbl_done", 32'(busy), 32'd0);
    end

    // Stall before second beat while the tracker inputs change.
    set_res(32'd9, E, 32'd4);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      set_res(32'($urandom), E, 32'($urandom));
      cycle(1'b0, 1'b0);
      chk("stall_data", m_data, 32'd4);
      chk("stall_index", 32'(m_index), 32'd2);
    end
    cycle(1'b0, 1'b1);
    chk("stall_done", 32'(busy), 32'd0);

    // snap_req held through a 3-beat frame and one cycle beyond.
    set_res(32'd50, 32'd30, 32'd10);
    for (int k = 0; k < 5; k++) cycle(1'b1, 1'b1);
    chk("hold_dropped", 32'(dropped_snaps), 32'd3);
    chk("hold_second_frame", 32'(busy), 32'd1);
    guard = 0;
    while (busy && guard < 10) begin cycle(1'b0, 1'b1); guard++; end
    chk("hold_drain", 32'(busy), 32'd0);

    // Saturation of the drop counter.
    cycle(1'b1, 1'b0);
    for (int k = 0; k < 300; k++) cycle(1'b1, 1'b0);
    chk("sat_dropped", 32'(dropped_snaps), 32'd255);
    guard = 0;
    while (busy && guard < 10) begin cycle(1'b0, 1'b1); guard++; end
    chk("sat_drain", 32'(busy), 32'd0);

    // Asynchronous reset after the first beat of a 3-beat frame.
    set_res(32'd50, 32'd30, 32'd10);
    cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b1);
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dropped", 32'(dropped_snaps), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1);
    set_res(32'd8, 32'd6, E);
    cycle(1'b1, 1'b1);
    chk("post_rst_data", m_data, 32'd8);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);

    // Randomised traffic against the model.
    for (int k = 0; k < 400; k++) begin
      set_res(rnd_val(), rnd_val(), rnd_val());
      cycle(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) != 0));
    end
    guard = 0;
    while (busy && guard < 10) begin cycle(1'b0, 1'b1); guard++; end
    chk("final_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
